// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// rf_wb_arbiter : round-robin writeback arbiter for the single RF write port
// Rev 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  output logic                  prio_b,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                  rf_wen_q,    rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q,     rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_dataD_q,  rf_dataD_d;
  logic                  prio_b_q,    prio_b_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  logic                  w_grant_a;
  logic                  w_grant_b;
  logic [ADDR_WIDTH-1:0] w_sel_rd;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_stall;

  // A grant already implies its valid, so ready doubles as accept.
  always_comb begin
    w_grant_a = ~freeze & a_valid & (~b_valid | ~prio_b_q);
    w_grant_b = ~freeze & b_valid & (~a_valid |  prio_b_q);
  end

  always_comb begin
    w_sel_rd    = w_grant_b ? b_rd   : a_rd;
    w_sel_data  = w_grant_b ? b_data : a_data;
    w_stall     = (a_valid & ~w_grant_a) | (b_valid & ~w_grant_b);

    rf_wen_d    = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_dataD_d  = rf_dataD_q;
    prio_b_d    = prio_b_q;
    stall_cnt_d = stall_cnt_q;

    if (w_grant_a || w_grant_b) begin
      rf_wen_d   = (w_sel_rd != '0);
      rf_rd_d    = w_sel_rd;
      rf_dataD_d = w_sel_data;
      prio_b_d   = w_grant_a;
    end

    if (w_stall && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_q    <= 1'b0;
      rf_rd_q     <= '0;
      rf_dataD_q  <= '0;
      prio_b_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      rf_wen_q    <= rf_wen_d;
      rf_rd_q     <= rf_rd_d;
      rf_dataD_q  <= rf_dataD_d;
      prio_b_q    <= prio_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign rf_wen    = rf_wen_q;
  assign rf_rd     = rf_rd_q;
  assign rf_dataD  = rf_dataD_q;
  assign prio_b    = prio_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
